core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM for the core: steps fetch -> decode -> execute -> write per instruction.
//  Drives each stage's one-cycle enable pulse and waits for its completed flag.
//  Captures the execute stage's jump result and owns the architectural PC (word-addressed).
//  Provides halt, watchdog timeout and a retired-instruction counter.
// PARAMETERS
//  PC_RESET       32'h0  PC loaded on start.
//  STAGE_TIMEOUT  16     Max wait cycles for a completed flag after the enable pulse.
//                        0 disables the watchdog.
// PORTS
//  clk              in   1   Clock.
//  rstn             in   1   Reset; synchronous, active-low.
//  start            in   1   Begin execution from PC_RESET. Honoured in IDLE, HALT or ERROR only.
//  halt_req         in   1   Stop after the current instruction retires. Sampled at write completion.
//  fetch_enabled    out  1   One-cycle start pulse to fetch.
//  fetch_completed  in   1   Fetch done.
//  decode_enabled   out  1   One-cycle start pulse to decode.
//  decode_completed in   1   Decode done.
//  exec_enabled     out  1   One-cycle start pulse to execute.
//  exec_completed   in   1   Execute done.
//  exec_is_jump     in   1   Execute jump taken. Valid only while exec_enabled=1.
//  exec_jump_dest   in   32  Execute next PC. Valid only while exec_enabled=1.
//  write_enabled    out  1   One-cycle start pulse to writeback.
//  write_completed  in   1   Writeback done.
//  pc               out  32  PC of the instruction in flight.
//  running          out  1   High in FETCH, DECODE, EXEC and WRITE.
//  halted           out  1   High in HALT.
//  error            out  1   High in ERROR (watchdog expired).
//  instr_count      out  32  Retired instructions since the last start. Wraps modulo 2^32.
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, WRITE, HALT, ERROR.
//  Reset (rstn=0 at posedge, from any state, including mid-stage):
//   - state=IDLE; all outputs 0; pc=0; instr_count=0.
//   - Captured jump info and the wait counter are cleared.
//  Start: in IDLE, HALT or ERROR, start=1 at posedge gives:
//   - pc=PC_RESET, instr_count=0, error=0, state=FETCH.
//   - start is ignored while running.
//  Stage protocol (identical for FETCH, DECODE, EXEC, WRITE):
//   - First cycle in the state: X_enabled=1 (exactly one cycle); the wait counter is cleared.
//   - X_completed is ignored during the enable cycle, because stages assert completed only
//     when enabled is low.
//   - Later cycles: X_enabled=0. When X_completed=1 at posedge, move to the next state.
//     The next stage's enable rises in the following cycle.
//   - Minimum of 2 cycles per stage, so 8 cycles per instruction.
//  EXEC capture:
//   - In the exec_enabled cycle, latch jmp=exec_is_jump and dest=exec_jump_dest.
//   - Later values on these inputs are don't-care.
//  WRITE completion:
//   - pc <= jmp ? dest : pc+1 (32-bit wrap); instr_count++.
//   - halt_req=1 at the same posedge: go to HALT. pc still advances and the instruction still counts.
//   - Otherwise go to FETCH.
//  Watchdog (STAGE_TIMEOUT>0):
//   - The counter increments on each post-enable wait cycle without completed.
//   - If it reaches STAGE_TIMEOUT: state=ERROR, error=1, pc frozen, no enables asserted.
//   - completed arriving in the same cycle the counter hits the limit wins; no error is raised.
//  HALT and ERROR are sticky until start or reset. No enables are driven in IDLE, HALT or ERROR.
//  At most one X_enabled is high in any cycle.
// TESTING
//  1. Reset, start; every stage returns completed one cycle after its enable.
//     -> Enables pulse F,D,E,W at cycles 1,3,5,7; pc 0->1; instr_count=1.
//  2. Exec cycle drives is_jump=1, dest=32'h40; the values change afterwards.
//     -> pc=32'h40 after write. The later values are ignored.
//  3. decode_completed withheld 16 cycles (STAGE_TIMEOUT=16).
//     -> error=1, running=0, no further enables. Then start -> error=0, pc=PC_RESET.
//  4. halt_req=1 held during the 3rd write completion.
//     -> halted=1, instr_count=3, pc=3. A late completed is ignored.
//  5. rstn=0 mid-EXEC wait -> next cycle: IDLE, all outputs 0.
//     A start pulse while running -> no effect.
//  6. pc=32'hFFFFFFFF without a jump -> pc wraps to 0.
//     completed asserted during an enable cycle -> ignored; the stage waits.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM stepping fetch -> decode -> execute -> write.
// Each stage gets a one-cycle enable pulse on entry and the FSM waits for its completed
// flag. Owns the word-addressed PC, captures the execute jump result, and provides halt,
// a per-stage watchdog and a retired-instruction counter.
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   start, halt_req                 run control
//   <stage>_enabled/_completed      per-stage handshake (fetch, decode, exec, write)
//   exec_is_jump, exec_jump_dest    execute result, valid while exec_enabled=1
//   pc, running, halted, error      architectural PC and status
//   instr_count                     retired instructions since the last start
module core_sequencer #(
    parameter logic [31:0] PC_RESET      = 32'h0,
    parameter int unsigned STAGE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt_req,
    output logic        fetch_enabled,
    input  logic        fetch_completed,
    output logic        decode_enabled,
    input  logic        decode_completed,
    output logic        exec_enabled,
    input  logic        exec_completed,
    input  logic        exec_is_jump,
    input  logic [31:0] exec_jump_dest,
    output logic        write_enabled,
    input  logic        write_completed,
    output logic [31:0] pc,
    output logic        running,
    output logic        halted,
    output logic        error,
    output logic [31:0] instr_count
);

    // Counter only ever holds values up to STAGE_TIMEOUT-1 before the stage resolves.
    localparam int unsigned CNT_W = (STAGE_TIMEOUT > 1) ? $clog2(STAGE_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
    logic               jmp_q, jmp_d;
    logic [31:0]        dest_q, dest_d;
    logic [31:0]        pc_d, instr_count_d;
    logic               fetch_en_d, decode_en_d, exec_en_d, write_en_d;
    logic               running_d, halted_d, error_d;
    logic               stage_en_c;
    logic               done_c;
    logic               wd_hit_c;

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            jmp_q          <= 1'b0;
            dest_q         <= '0;
            pc             <= '0;
            instr_count    <= '0;
            fetch_enabled  <= 1'b0;
            decode_enabled <= 1'b0;
            exec_enabled   <= 1'b0;
            write_enabled  <= 1'b0;
            running        <= 1'b0;
            halted         <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_d;
            wait_cnt       <= wait_cnt_d;
            jmp_q          <= jmp_d;
            dest_q         <= dest_d;
            pc             <= pc_d;
            instr_count    <= instr_count_d;
            fetch_enabled  <= fetch_en_d;
            decode_enabled <= decode_en_d;
            exec_enabled   <= exec_en_d;
            write_enabled  <= write_en_d;
            running        <= running_d;
            halted         <= halted_d;
            error          <= error_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d       = state;
        wait_cnt_d    = wait_cnt;
        jmp_d         = jmp_q;
        dest_d        = dest_q;
        pc_d          = pc;
        instr_count_d = instr_count;

        // The registered enable marks the first cycle of a stage; completed is ignored then.
        stage_en_c = fetch_enabled | decode_enabled | exec_enabled | write_enabled;

        case (state)
            FETCH:   done_c = fetch_completed;
            DECODE:  done_c = decode_completed;
            EXEC:    done_c = exec_completed;
            WRITE:   done_c = write_completed;
            default: done_c = 1'b0;
        endcase

        wd_hit_c = (STAGE_TIMEOUT != 0) && (wait_cnt == CNT_W'(STAGE_TIMEOUT - 1));

        case (state)
            IDLE, HALT, ERROR: begin
                if (start) begin
                    state_d       = FETCH;
                    pc_d          = PC_RESET;
                    instr_count_d = '0;
                end
            end
            FETCH, DECODE, EXEC, WRITE: begin
                if (stage_en_c) begin
                    wait_cnt_d = '0;
                    if (state == EXEC) begin
                        jmp_d  = exec_is_jump;
                        dest_d = exec_jump_dest;
                    end
                end else if (done_c) begin
                    // Completion wins over a watchdog hit in the same cycle.
                    wait_cnt_d = '0;
                    case (state)
                        FETCH:   state_d = DECODE;
                        DECODE:  state_d = EXEC;
                        EXEC:    state_d = WRITE;
                        default: begin
                            pc_d          = jmp_q ? dest_q : pc + 32'd1;
                            instr_count_d = instr_count + 32'd1;
                            state_d       = halt_req ? HALT : FETCH;
                        end
                    endcase
                end else if (wd_hit_c) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = CNT_W'(wait_cnt + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Enables pulse only on entry into a stage state.
        fetch_en_d  = (state_d == FETCH)  && (state != FETCH);
        decode_en_d = (state_d == DECODE) && (state != DECODE);
        exec_en_d   = (state_d == EXEC)   && (state != EXEC);
        write_en_d  = (state_d == WRITE)  && (state != WRITE);

        running_d = (state_d == FETCH) || (state_d == DECODE) ||
                    (state_d == EXEC)  || (state_d == WRITE);
        halted_d  = (state_d == HALT);
        error_d   = (state_d == ERROR);
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer. Expected post-write PC and
// retired count are pushed when the execute result is driven and popped at write completion.
module tb_core_sequencer;

    localparam logic [31:0] PC_RST = 32'h0;
    localparam int unsigned TMO    = 16;

    logic        clk = 1'b0;
    logic        rstn, start, halt_req;
    logic        fetch_enabled, fetch_completed;
    logic        decode_enabled, decode_completed;
    logic        exec_enabled, exec_completed, exec_is_jump;
    logic [31:0] exec_jump_dest;
    logic        write_enabled, write_completed;
    logic [31:0] pc, instr_count;
    logic        running, halted, error;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc, m_cnt;
    int          total = 0;
    int          bad   = 0;

    core_sequencer #(.PC_RESET(PC_RST), .STAGE_TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
        .fetch_enabled(fetch_enabled), .fetch_completed(fetch_completed),
        .decode_enabled(decode_enabled), .decode_completed(decode_completed),
        .exec_enabled(exec_enabled), .exec_completed(exec_completed),
        .exec_is_jump(exec_is_jump), .exec_jump_dest(exec_jump_dest),
        .write_enabled(write_enabled), .write_completed(write_completed),
        .pc(pc), .running(running), .halted(halted), .error(error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running, required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] en_vec();
        return {28'd0, write_enabled, exec_enabled, decode_enabled, fetch_enabled};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_comp(input int idx, input logic v);
        case (idx)
            0: fetch_completed  = v;
            1: decode_completed = v;
            2: exec_completed   = v;
            default: write_completed = v;
        endcase
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, en_vec(), 32'd0);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_cnt"}, instr_count, 32'd0);
        check({tag, "_stat"}, {29'd0, running, halted, error}, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        check_idle_outputs("reset");
        rstn = 1'b1;
        m_pc = 32'd0;
        m_cnt = 32'd0;
    endtask

    // Leaves the bench at the negedge of the fetch enable cycle.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = PC_RST;
        m_cnt = 32'd0;
        check("start_err", {31'd0, error}, 32'd0);
        check("start_run", {31'd0, running}, 32'd1);
        check("start_cnt", instr_count, 32'd0);
    endtask

    // Called at the negedge of the stage's enable cycle; dly wait cycles precede completion.
    task automatic stage(input int idx, input int dly, input bit early,
                         input bit jmp, input logic [31:0] dest, input bit hlt);
        exp_t e;
        check($sformatf("en_s%0d", idx), en_vec(), 32'd1 << idx);
        check($sformatf("pc_s%0d", idx), pc, m_pc);
        if (idx == 2) begin
            exec_is_jump   = jmp;
            exec_jump_dest = dest;
            e.pc  = jmp ? dest : m_pc + 32'd1;
            e.cnt = m_cnt + 32'd1;
            sb.push_back(e);
        end
        set_comp(idx, early);
        tick();
        if (idx == 2) begin
            exec_is_jump   = ~jmp;
            exec_jump_dest = ~dest;
        end
        set_comp(idx, 1'b0);
        for (int i = 0; i < dly; i++) tick();
        check($sformatf("wait_en_s%0d", idx), en_vec(), 32'd0);
        set_comp(idx, 1'b1);
        if (idx == 3) halt_req = hlt;
        tick();
        set_comp(idx, 1'b0);
        halt_req = 1'b0;
    endtask

    task automatic run_instr(input int d0, input int d1, input int d2, input int d3,
                             input int early_idx, input bit jmp, input logic [31:0] dest,
                             input bit hlt);
        exp_t e;
        stage(0, d0, early_idx == 0, 1'b0, 32'd0, 1'b0);
        stage(1, d1, early_idx == 1, 1'b0, 32'd0, 1'b0);
        stage(2, d2, early_idx == 2, jmp, dest, 1'b0);
        stage(3, d3, early_idx == 3, 1'b0, 32'd0, hlt);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("retire_pc", pc, e.pc);
            check("retire_cnt", instr_count, e.cnt);
            check("retire_halt", {31'd0, halted}, {31'd0, hlt});
            check("retire_fetch", {31'd0, fetch_enabled}, {31'd0, !hlt});
            m_pc  = e.pc;
            m_cnt = e.cnt;
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; halt_req = 1'b0;
        fetch_completed = 1'b0; decode_completed = 1'b0;
        exec_completed = 1'b0; write_completed = 1'b0;
        exec_is_jump = 1'b0; exec_jump_dest = 32'd0;
        tick();

        // Basic flow with minimum latency, then a jump with later-changing exec inputs.
        do_reset();
        do_start();
        run_instr(0, 0, 0, 0, -1, 1'b0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 0, -1, 1'b1, 32'h40, 1'b0);
        run_instr(2, 1, 3, 0, -1, 1'b0, 32'h1234, 1'b0);

        // Completion on the last allowed wait cycle wins; then decode times out.
        do_reset();
        do_start();
        stage(0, TMO - 1, 1'b0, 1'b0, 32'd0, 1'b0);
        check("wd_dec_en", en_vec(), 32'd2);
        tick();
        for (int i = 1; i < int'(TMO); i++) begin
            check($sformatf("wd_noerr_%0d", i), {31'd0, error}, 32'd0);
            tick();
        end
        check("wd_noerr_last", {31'd0, error}, 32'd0);
        tick();
        check("wd_err", {31'd0, error}, 32'd1);
        check("wd_run", {31'd0, running}, 32'd0);
        check("wd_pc", pc, m_pc);
        decode_completed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wd_sticky_en", en_vec(), 32'd0);
            check("wd_sticky_err", {31'd0, error}, 32'd1);
        end
        decode_completed = 1'b0;
        do_start();
        check("wd_restart_pc", pc, PC_RST);
        run_instr(0, 0, 0, 0, -1, 1'b0, 32'd0, 1'b0);

        // Halt on the third write completion; late completions are ignored.
        do_reset();
        do_start();
        run_instr(0, 0, 0, 0, -1, 1'b0, 32'd0, 1'b0);
        run_instr(0, 1, 0, 2, -1, 1'b0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 0, -1, 1'b0, 32'd0, 1'b1);
        check("halt_cnt", instr_count, 32'd3);
        check("halt_pc", pc, 32'd3);
        write_completed = 1'b1;
        fetch_completed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_sticky", {29'd0, running, halted, error}, 32'd2);
            check("halt_en", en_vec(), 32'd0);
        end
        write_completed = 1'b0;
        fetch_completed = 1'b0;
        check("halt_pc_hold", pc, 32'd3);

        // Start while running is ignored; reset mid execute wait clears everything.
        do_reset();
        do_start();
        stage(0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        stage(1, 0, 1'b0, 1'b0, 32'd0, 1'b0);
        check("mid_exec_en", en_vec(), 32'd4);
        exec_is_jump = 1'b1;
        exec_jump_dest = 32'h99;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_en", en_vec(), 32'd0);
        check("run_start_run", {31'd0, running}, 32'd1);
        check("run_start_pc", pc, m_pc);
        rstn = 1'b0;
        tick();
        check_idle_outputs("mid_reset");
        rstn = 1'b1;
        exec_is_jump = 1'b0;
        tick();
        check_idle_outputs("idle_hold");

        // PC wrap without a jump; completed during an enable cycle is ignored.
        do_reset();
        do_start();
        run_instr(0, 0, 0, 0, -1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("wrap_pre", pc, 32'hFFFF_FFFF);
        run_instr(0, 0, 0, 0, 1, 1'b0, 32'd0, 1'b0);
        check("wrap_pc", pc, 32'd0);
        run_instr(0, 0, 0, 0, 3, 1'b0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
